// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the data memory controller (slave).
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       ST_val;
  logic [1:0]        size;
  logic              sign_ext;
  logic [31:0]       Mem_read_value;
  logic              rd_valid;
  logic              busy;
  logic              misaligned;

  modport master (
    output MEM_R_EN, MEM_W_EN, Address, ST_val, size, sign_ext,
    input  Mem_read_value, rd_valid, busy, misaligned
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, Address, ST_val, size, sign_ext,
    output Mem_read_value, rd_valid, busy, misaligned
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Little-endian byte-addressed data memory with sized/extended loads, lane-masked stores,
// configurable read latency, busy stall and misalignment rejection.
module data_memory_ctrl #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  data_memory_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] capWord_q, capWord_d;
  logic [1:0]        capLane_q, capLane_d;
  logic [1:0]        capSize_q, capSize_d;
  logic              capSext_q, capSext_d;
  logic              pendLoad_q, pendLoad_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic              rdValid_q, rdValid_d;
  logic              misal_q, misal_d;

  logic [IDX_W-1:0]  wordIdx;
  logic [1:0]        lane;
  logic              isByte, isHalf, alignOk, reqAny, accept, doStore, doLoad;
  logic [3:0]        laneEn;
  logic [DATA_W-1:0] wrData;
  logic              unusedAddrBits;

  assign wordIdx        = bus.Address[IDX_W+1:2];
  assign lane           = bus.Address[1:0];
  assign unusedAddrBits = ^bus.Address[ADDR_W-1:IDX_W+2];
  assign isByte         = (bus.size == 2'b00);
  assign isHalf         = (bus.size == 2'b01);
  assign alignOk        = isByte || (isHalf && !lane[0]) || (!isByte && !isHalf && lane == 2'b00);
  assign reqAny         = bus.MEM_R_EN || bus.MEM_W_EN;
  assign accept         = (state_q == IDLE) && reqAny && alignOk;
  assign doStore        = accept && bus.MEM_W_EN;
  assign doLoad         = accept && bus.MEM_R_EN && !bus.MEM_W_EN;

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] word,
                                                input logic [1:0] ln,
                                                input logic [1:0] sz,
                                                input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{ln, 3'b000} +: 8];
    h = ln[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   extract = {{24{sx & b[7]}}, b};
      2'b01:   extract = {{16{sx & h[15]}}, h};
      default: extract = word;
    endcase
  endfunction

  // Store data is replicated across lanes so the lane mask alone selects what lands.
  always_comb begin
    laneEn = 4'b1111;
    wrData = bus.ST_val;
    case (bus.size)
      2'b00: begin
        laneEn = 4'b0001 << lane;
        wrData = {4{bus.ST_val[7:0]}};
      end
      2'b01: begin
        laneEn = lane[1] ? 4'b1100 : 4'b0011;
        wrData = {2{bus.ST_val[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capWord_d  = capWord_q;
    capLane_d  = capLane_q;
    capSize_d  = capSize_q;
    capSext_d  = capSext_q;
    pendLoad_d = pendLoad_q;
    rdData_d   = rdData_q;
    rdValid_d  = 1'b0;
    misal_d    = (state_q == IDLE) && reqAny && !alignOk;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            if (doLoad) begin
              rdValid_d = 1'b1;
              rdData_d  = extract(mem[wordIdx], lane, bus.size, bus.sign_ext);
            end
          end else begin
            state_d    = WAIT;
            cnt_d      = CNT_W'(LATENCY - 1);
            pendLoad_d = doLoad;
            capWord_d  = mem[wordIdx];
            capLane_d  = lane;
            capSize_d  = bus.size;
            capSext_d  = bus.sign_ext;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // The edge that leaves WAIT is the one that delivers the load result.
        if (cnt_q == CNT_W'(1)) begin
          state_d    = IDLE;
          pendLoad_d = 1'b0;
          if (pendLoad_q) begin
            rdValid_d = 1'b1;
            rdData_d  = extract(capWord_q, capLane_q, capSize_q, capSext_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      capWord_q  <= '0;
      capLane_q  <= '0;
      capSize_q  <= '0;
      capSext_q  <= 1'b0;
      pendLoad_q <= 1'b0;
      rdData_q   <= '0;
      rdValid_q  <= 1'b0;
      misal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      capWord_q  <= capWord_d;
      capLane_q  <= capLane_d;
      capSize_q  <= capSize_d;
      capSext_q  <= capSext_d;
      pendLoad_q <= pendLoad_d;
      rdData_q   <= rdData_d;
      rdValid_q  <= rdValid_d;
      misal_q    <= misal_d;
    end
  end

  // Array contents survive reset, so a store committed at accept is never rolled back.
  always_ff @(posedge clk) begin
    if (doStore) begin
      for (int l = 0; l < 4; l++) begin
        if (laneEn[l]) mem[wordIdx][8*l +: 8] <= wrData[8*l +: 8];
      end
    end
  end

  assign bus.Mem_read_value = rdData_q;
  assign bus.rd_valid       = rdValid_q;
  assign bus.busy           = (state_q == WAIT);
  assign bus.misaligned     = misal_q;
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor to the pipeline's data memory, placed in the MEM stage.
- Adds byte/halfword/word loads and stores with sign or zero extension, and byte-lane write enables.
- Adds a registered read path with configurable access latency, a busy signal that stalls the pipeline, and misalignment detection.
- Memory is little-endian and byte-addressed.

Parameters:
- DATA_W, 32, data word width; fixed at 32 for MIPS, with 4 byte lanes.
- DEPTH, 64, number of words; must be a power of 2.
- ADDR_W, 32, width of the byte address input.
- LATENCY, 1, cycles from accept to read data valid; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- Address  in  ADDR_W  byte address.
- ST_val  in  32  store data, right-justified.
- size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends.
- Mem_read_value  out  32  load result, held until the next load completes.
- rd_valid  out  1  one-cycle pulse when Mem_read_value is updated.
- busy  out  1  high while an access is in flight; pipeline must freeze.
- misaligned  out  1  one-cycle pulse when a request is rejected for alignment.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; latency counter cleared.
  - Mem_read_value=0, rd_valid=0, busy=0, misaligned=0.
  - Array contents are NOT cleared.
- Word index = Address[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Lane = Address[1:0]; lane 0 is bits 7:0.
- Alignment:
  - Halfword requires Address[0]=0.
  - Word requires Address[1:0]=00.
  - A violation in IDLE: no array access, misaligned=1 for the next cycle, FSM stays in IDLE, busy stays 0.
- Accept:
  - Occurs on a rising edge with FSM in IDLE, (MEM_R_EN|MEM_W_EN)=1 and alignment OK.
  - If both enables are high, the store wins and the read is dropped (no rd_valid).
- Store:
  - Array updated at the accept edge, only on the selected lanes.
  - Byte: ST_val[7:0] to lane Address[1:0].
  - Halfword: ST_val[15:0] to lanes {1,0} when Address[1]=0, lanes {3,2} when Address[1]=1.
  - Word: all 4 lanes.
  - Other lanes are unchanged.
- Load:
  - The addressed word is captured at the accept edge.
  - The selected byte or halfword is extracted and extended per sign_ext.
  - Sign bit is bit 7 for byte and bit 15 for halfword; word loads ignore sign_ext.
- FSM states: IDLE, WAIT.
  - LATENCY=1: FSM stays in IDLE and busy is never asserted. A load's Mem_read_value and rd_valid=1 appear in the cycle after accept.
  - LATENCY>1: on accept, FSM goes IDLE→WAIT and the counter is loaded with LATENCY-1.
  - In WAIT, busy=1 and the counter decrements each edge; at 0, FSM returns to IDLE.
  - For loads, Mem_read_value updates and rd_valid pulses on the edge that leaves WAIT. That is LATENCY cycles after accept; busy drops in the same cycle.
  - Stores also hold busy for LATENCY-1 cycles, with no rd_valid.
- Requests while busy=1 are ignored; the requester holds them until busy=0.
- rd_valid and misaligned are single-cycle pulses, never asserted together.
- Reset during WAIT aborts the access:
  - A pending load result is discarded.
  - A store already committed at accept remains in the array.

Test Plan:
- LATENCY=1, word store 0xDEADBEEF to 0x10, then word load 0x10 → next cycle Mem_read_value=0xDEADBEEF, rd_valid=1 for 1 cycle, busy=0 throughout.
- Byte store 0x80 to 0x13 over word 0x00000000, then byte load with sign_ext=1 → 0xFFFFFF80; with sign_ext=0 → 0x00000080; word load 0x10 → 0x80000000.
- Halfword load from 0x11 → misaligned=1 for 1 cycle, rd_valid=0, Mem_read_value unchanged. Word store to 0x12 → array unchanged.
- LATENCY=3, load 0x10 → busy=1 for 2 cycles; rd_valid and data at accept+3. A different load issued while busy produces no extra rd_valid.
- MEM_R_EN=MEM_W_EN=1, word to 0x20 with 0x12345678 → array updated, no rd_valid. Address 0x120 with DEPTH=64 reads back the same word (wrap).
- LATENCY=4, assert rst 1 cycle after a load is accepted → busy=0, Mem_read_value=0, no rd_valid afterwards. A store accepted before rst reads back intact.
